// File: rtl/comparator_pkg.sv
// Shared opcode and FSM state types for the iterative comparator, plus small
// opcode decode helpers used by the datapath and result mapping.
package comparator_pkg;

  typedef enum logic [3:0] {
    OP_SLT  = 4'b0101,
    OP_SGT  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_SGTU = 4'b1000,
    OP_EQ   = 4'b1001,
    OP_NE   = 4'b1010
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } cmp_state_e;

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_SLT) || (op == OP_SGT);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= OP_SLT) && (op <= OP_NE);
  endfunction

  // No decision after the full scan means the operands are equal.
  function automatic logic cmp_result(input logic [3:0] op, input logic lt, input logic gt);
    logic r;
    r = 1'b0;
    case (op)
      OP_SLT, OP_SLTU: r = lt;
      OP_SGT, OP_SGTU: r = gt;
      OP_EQ:           r = !(lt || gt);
      OP_NE:           r = lt || gt;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/iterative_comparator_if.sv
// Operand/opcode request and Result response handshakes of the iterative comparator.
interface iterative_comparator_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             ZeroFlag;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, Result, ZeroFlag
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, Result, ZeroFlag
  );
endinterface

// File: rtl/chunk_compare.sv
// Unsigned magnitude compare of one CHUNK-bit slice of the operands.
module chunk_compare #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             gt
);
  assign lt = (a < b);
  assign gt = (a > b);
endmodule

// File: rtl/iterative_comparator.sv
// Multi-cycle WIDTH-bit comparator scanning CHUNK bits per cycle, MSB chunk first.
// Define ITERATIVE_COMPARATOR_EARLY_EXIT_EN to stop at the first differing chunk.
module iterative_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  iterative_comparator_if.slave bus
);

  localparam int NCHUNK = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef ITERATIVE_COMPARATOR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % ((CHUNK >= 1) ? CHUNK : 1)) != 0) begin : g_bad_params
    $error("iterative_comparator: need WIDTH >= 2 and CHUNK >= 1 dividing WIDTH");
  end

  cmp_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       op_q;
  logic             lt_q, gt_q, lt_d, gt_d;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             chunk_lt, chunk_gt;
  logic             new_decision;
  logic             accept;

  assign accept       = (state_q == IDLE) && bus.in_valid;
  assign a_chunk      = a_q[int'(idx_q) * CHUNK +: CHUNK];
  assign b_chunk      = b_q[int'(idx_q) * CHUNK +: CHUNK];
  assign new_decision = !(lt_q || gt_q) && (chunk_lt || chunk_gt);

  chunk_compare #(
    .CHUNK(CHUNK)
  ) u_chunk_compare (
    .a (a_chunk),
    .b (b_chunk),
    .lt(chunk_lt),
    .gt(chunk_gt)
  );

  // Illegal opcodes still spend one SCAN cycle so every operation has n >= 1.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    lt_d     = lt_q;
    gt_d     = gt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SCAN;
          idx_d   = IDX_W'(NCHUNK - 1);
          lt_d    = 1'b0;
          gt_d    = 1'b0;
        end
      end
      SCAN: begin
        if (new_decision) begin
          lt_d = chunk_lt;
          gt_d = chunk_gt;
        end
        if (idx_q == '0 || !is_legal_op(op_q) || (EARLY_EXIT && new_decision)) begin
          state_d  = DONE;
          result_d = {{(WIDTH-1){1'b0}}, cmp_result(op_q, lt_d, gt_d)};
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Flipping both MSBs turns a signed compare into an unsigned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      lt_q     <= 1'b0;
      gt_q     <= 1'b0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
    end else begin
      idx_q    <= idx_d;
      lt_q     <= lt_d;
      gt_q     <= gt_d;
      result_q <= result_d;
      if (accept) begin
        a_q  <= bus.A ^ (is_signed_op(bus.opcode) ? MSB_MASK : '0);
        b_q  <= bus.B ^ (is_signed_op(bus.opcode) ? MSB_MASK : '0);
        op_q <= bus.opcode;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Result    = result_q;
  assign bus.ZeroFlag  = ~|result_q;

endmodule
